// File: rtl/spi_flash_read_buffer.sv
// Read-burst sequencer for a quad-SPI shifter with a first-word-fall-through word FIFO.
// A burst starts only once the FIFO can absorb the whole burst, because the shifter cannot be stalled.
module spi_flash_read_buffer #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       requestValid,
  input  logic [23:0]                requestAddress,
  input  logic [FIFO_DEPTH_LOG2:0]   requestLength,
  output logic                       requestReady,
  output logic                       flashStart,
  output logic [23:0]                flashAddress,
  output logic [7:0]                 flashNrOfWords,
  input  logic                       flashDataValid,
  input  logic [31:0]                flashData,
  output logic                       wordValid,
  output logic [31:0]                wordData,
  output logic                       wordLast,
  input  logic                       wordReady,
  output logic                       busy,
  output logic                       overflowError
);

  localparam int L = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << L;
  localparam logic [L:0]   DEPTH_CNT = (L+1)'(DEPTH);
  localparam logic [L:0]   CNT_ONE   = (L+1)'(1);
  localparam logic [L-1:0] PTR_ONE   = L'(1);

  typedef enum logic [1:0] {IDLE, WAITSPACE, START, RECEIVE} state_t;

  state_t       state_reg;
  logic         ready_reg;
  logic         busy_reg;
  logic         start_reg;
  logic [23:0]  addr_reg;
  logic [L:0]   len_reg;
  logic [L:0]   len_m1_reg;
  logic [L:0]   rcv_reg;
  logic [L:0]   count_reg;
  logic [L:0]   free_reg;
  logic [L-1:0] wr_ptr_reg;
  logic [L-1:0] rd_ptr_reg;
  logic         overflow_reg;
  logic [32:0]  mem [DEPTH];

  logic [L:0]   len_eff;
  logic [L:0]   count_next;
  logic         push_req;
  logic         push;
  logic         pop;
  logic         full;
  logic         last_word;
  logic [32:0]  head;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^requestAddress[1:0];

  assign len_eff   = (requestLength == '0) ? DEPTH_CNT : requestLength;
  assign full      = (count_reg == DEPTH_CNT);
  assign pop       = (count_reg != '0) && wordReady;
  assign push_req  = (state_reg == RECEIVE) && flashDataValid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push      = push_req && (!full || pop);
  assign last_word = (rcv_reg == len_m1_reg);

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_ONE;
    else if (pop && !push)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      start_reg    <= 1'b0;
      addr_reg     <= '0;
      len_reg      <= '0;
      len_m1_reg   <= '0;
      rcv_reg      <= '0;
      count_reg    <= '0;
      free_reg     <= DEPTH_CNT;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (requestValid) begin
            addr_reg   <= {requestAddress[23:2], 2'b00};
            len_reg    <= len_eff;
            len_m1_reg <= len_eff - CNT_ONE;
            state_reg  <= WAITSPACE;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b1;
          end
        end
        WAITSPACE: begin
          if (free_reg >= len_reg) begin
            state_reg <= START;
            start_reg <= 1'b1;
          end
        end
        START: begin
          state_reg <= RECEIVE;
          rcv_reg   <= '0;
        end
        RECEIVE: begin
          if (push_req) begin
            rcv_reg <= rcv_reg + CNT_ONE;
            if (last_word) begin
              state_reg <= IDLE;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      free_reg  <= DEPTH_CNT - count_next;
      if (push_req && full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= {last_word, flashData};
  end

  assign head = mem[rd_ptr_reg];

  assign requestReady   = ready_reg;
  assign flashStart     = start_reg;
  assign busy           = busy_reg;
  assign flashAddress   = addr_reg;
  assign flashNrOfWords = 8'(len_m1_reg);
  assign overflowError  = overflow_reg;
  assign wordValid      = (count_reg != '0);
  assign wordData       = wordValid ? head[31:0] : 32'd0;
  assign wordLast       = wordValid & head[32];

endmodule

// File: tb/tb_spi_flash_read_buffer.sv
// Directed bench for spi_flash_read_buffer: single word, full burst, space wait,
// push/pop at full across pointer wrap, overflow and reset mid-burst.
module tb_spi_flash_read_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        requestValid = 1'b0;
  logic [23:0] requestAddress = '0;
  logic [4:0]  requestLength = '0;
  logic        requestReady;
  logic        flashStart;
  logic [23:0] flashAddress;
  logic [7:0]  flashNrOfWords;
  logic        flashDataValid = 1'b0;
  logic [31:0] flashData = '0;
  logic        wordValid;
  logic [31:0] wordData;
  logic        wordLast;
  logic        wordReady = 1'b0;
  logic        busy;
  logic        overflowError;

  int tests = 0;
  int fails = 0;

  spi_flash_read_buffer #(.FIFO_DEPTH_LOG2(4)) dut (
    .clock(clock), .reset(reset),
    .requestValid(requestValid), .requestAddress(requestAddress),
    .requestLength(requestLength), .requestReady(requestReady),
    .flashStart(flashStart), .flashAddress(flashAddress),
    .flashNrOfWords(flashNrOfWords), .flashDataValid(flashDataValid),
    .flashData(flashData), .wordValid(wordValid), .wordData(wordData),
    .wordLast(wordLast), .wordReady(wordReady), .busy(busy),
    .overflowError(overflowError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [23:0] a, input logic [4:0] n);
    check("req_ready", {31'd0, requestReady}, 32'd1);
    requestValid = 1'b1;
    requestAddress = a;
    requestLength = n;
    tick();
    requestValid = 1'b0;
    $display("[TB] request addr=0x%06h len=%0d", a, n);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (flashStart !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_start"}, {31'd0, flashStart}, 32'd1);
  endtask

  task automatic strobe(input logic [31:0] d, input logic p);
    flashDataValid = 1'b1;
    flashData = d;
    wordReady = p;
    tick();
    flashDataValid = 1'b0;
    wordReady = 1'b0;
    $display("[TB] strobe data=0x%08h pop=%0d", d, p);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic last);
    check({tag, "_valid"}, {31'd0, wordValid}, 32'd1);
    check({tag, "_data"}, wordData, d);
    check({tag, "_last"}, {31'd0, wordLast}, {31'd0, last});
    wordReady = 1'b1;
    tick();
    wordReady = 1'b0;
    $display("[TB] pop expect=0x%08h last=%0d", d, last);
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", {31'd0, requestReady}, 32'd1);
    check("rst_start", {31'd0, flashStart}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wvalid", {31'd0, wordValid}, 32'd0);
    check("rst_wlast", {31'd0, wordLast}, 32'd0);
    check("rst_ovf", {31'd0, overflowError}, 32'd0);
    check("rst_addr", {8'd0, flashAddress}, 32'd0);
    check("rst_nr", {24'd0, flashNrOfWords}, 32'd0);
    check("rst_wdata", wordData, 32'd0);
    reset = 1'b0;

    // single word
    request(24'h000104, 5'd1);
    check("sw_busy", {31'd0, busy}, 32'd1);
    check("sw_notready", {31'd0, requestReady}, 32'd0);
    wait_start("sw");
    check("sw_nr", {24'd0, flashNrOfWords}, 32'd0);
    check("sw_addr", {8'd0, flashAddress}, 32'h000104);
    tick();
    check("sw_start_pulse", {31'd0, flashStart}, 32'd0);
    strobe(32'hDEADBEEF, 1'b0);
    check("sw_idle", {31'd0, busy}, 32'd0);
    pop_expect("sw_word", 32'hDEADBEEF, 1'b1);
    check("sw_empty", {31'd0, wordValid}, 32'd0);

    // full burst, length 0 means 16; address low bits dropped
    request(24'h123457, 5'd0);
    wait_start("fb");
    check("fb_nr", {24'd0, flashNrOfWords}, 32'd15);
    check("fb_addr", {8'd0, flashAddress}, 32'h123454);
    tick();
    for (int i = 0; i < 16; i++) strobe(32'hA000_0000 + i, 1'b0);
    check("fb_idle", {31'd0, busy}, 32'd0);
    check("fb_ovf", {31'd0, overflowError}, 32'd0);

    // space wait: leave 10 words, ask for 8
    for (int i = 0; i < 6; i++) pop_expect("fb_pop", 32'hA000_0000 + i, 1'b0);
    request(24'h000200, 5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sp_hold", {31'd0, flashStart}, 32'd0);
      check("sp_busy", {31'd0, busy}, 32'd1);
    end
    pop_expect("sp_pop", 32'hA000_0006, 1'b0);
    check("sp_hold1", {31'd0, flashStart}, 32'd0);
    pop_expect("sp_pop", 32'hA000_0007, 1'b0);
    check("sp_hold2", {31'd0, flashStart}, 32'd0);
    tick();
    check("sp_start_next", {31'd0, flashStart}, 32'd1);
    tick();
    for (int i = 0; i < 8; i++) strobe(32'hB000_0000 + i, 1'b0);
    check("sp_idle", {31'd0, busy}, 32'd0);

    // push and pop together while full, across pointer wrap
    request(24'h000000, 5'd2);
    tick();
    check("pp_hold", {31'd0, flashStart}, 32'd0);
    force dut.free_reg = 5'd16;
    wait_start("pp");
    release dut.free_reg;
    tick();
    check("pp_head0", wordData, 32'hA000_0008);
    strobe(32'hC000_0000, 1'b1);
    check("pp_ovf0", {31'd0, overflowError}, 32'd0);
    check("pp_head1", wordData, 32'hA000_0009);
    strobe(32'hC000_0001, 1'b1);
    check("pp_ovf1", {31'd0, overflowError}, 32'd0);
    check("pp_idle", {31'd0, busy}, 32'd0);
    for (int i = 10; i < 16; i++) pop_expect("pp_a", 32'hA000_0000 + i, i == 15);
    for (int i = 0; i < 8; i++) pop_expect("pp_b", 32'hB000_0000 + i, i == 7);
    pop_expect("pp_c", 32'hC000_0000, 1'b0);
    pop_expect("pp_c", 32'hC000_0001, 1'b1);
    check("pp_empty", {31'd0, wordValid}, 32'd0);

    // overflow: strobes into a full FIFO are dropped
    request(24'h000300, 5'd0);
    wait_start("ovfill");
    tick();
    for (int i = 0; i < 16; i++) strobe(32'hD000_0000 + i, 1'b0);
    request(24'h000400, 5'd2);
    force dut.free_reg = 5'd16;
    wait_start("ov");
    release dut.free_reg;
    tick();
    check("ov_before", {31'd0, overflowError}, 32'd0);
    strobe(32'hE000_0000, 1'b0);
    check("ov_set", {31'd0, overflowError}, 32'd1);
    strobe(32'hE000_0001, 1'b0);
    check("ov_idle", {31'd0, busy}, 32'd0);
    tick();
    tick();
    check("ov_sticky", {31'd0, overflowError}, 32'd1);
    for (int i = 0; i < 16; i++) pop_expect("ov_d", 32'hD000_0000 + i, i == 15);
    check("ov_dropped", {31'd0, wordValid}, 32'd0);
    check("ov_sticky2", {31'd0, overflowError}, 32'd1);

    // reset mid-burst
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_ovf_clr", {31'd0, overflowError}, 32'd0);
    request(24'h000500, 5'd8);
    wait_start("rb");
    tick();
    for (int i = 0; i < 3; i++) strobe(32'hF000_0000 + i, 1'b0);
    check("rb_partial", {31'd0, wordValid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_wvalid", {31'd0, wordValid}, 32'd0);
    check("rb_ready", {31'd0, requestReady}, 32'd1);
    check("rb_busy", {31'd0, busy}, 32'd0);
    check("rb_addr", {8'd0, flashAddress}, 32'd0);
    strobe(32'h5555_AAAA, 1'b0);
    check("rb_stray", {31'd0, wordValid}, 32'd0);
    check("rb_stray_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
